// File: rtl/clock_time_ctrl_pkg.sv
// clock_pkg: mode encoding and BCD limits shared by the
// clock sequencer, its key debouncers and its interface.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  localparam logic [3:0] BCD_MAX_L     = 4'd9;
  localparam logic [3:0] SEC_MIN_MAX_H = 4'd5;

  function automatic logic is_59(
    input logic [3:0] h,
    input logic [3:0] l
  );
    return (h == SEC_MIN_MAX_H) && (l == BCD_MAX_L);
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// clock_time_ctrl_if: tick, keys, live BCD time and the
// enable/mode/blink outputs of the clock sequencer.
interface clock_time_ctrl_if;
  import clock_pkg::*;

  logic       Tick1Hz;
  logic       KeyMode;
  logic       KeyInc;
  logic [3:0] SecH;
  logic [3:0] SecL;
  logic [3:0] MinH;
  logic [3:0] MinL;
  logic [3:0] HrH;
  logic [3:0] HrL;
  logic       EnSec;
  logic       EnMin;
  logic       EnHr;
  logic       SecClr;
  logic [1:0] Mode;
  logic       Blink;

  modport master (
    output Tick1Hz, KeyMode, KeyInc,
    output SecH, SecL, MinH, MinL, HrH, HrL,
    input  EnSec, EnMin, EnHr, SecClr, Mode, Blink
  );

  modport slave (
    input  Tick1Hz, KeyMode, KeyInc,
    input  SecH, SecL, MinH, MinL, HrH, HrL,
    output EnSec, EnMin, EnHr, SecClr, Mode, Blink
  );

endinterface

// File: rtl/clock_time_ctrl_key_debounce.sv
// key_debounce: 2-flop synchronizer plus stability counter;
// emits a one-cycle Press on each accepted 0->1 level change.
module key_debounce
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic CP,
  input  logic CLR,
  input  logic KeyRaw,
  output logic Level,
  output logic Press
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_lock;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff = (r_s2 != r_level);
  assign w_done = w_diff && (r_cnt == CNT_LAST) && !r_lock;

  // Free-running synchronizer so a key held across reset stays visible.
  always_ff @(posedge CP) begin
    r_s1 <= KeyRaw;
    r_s2 <= r_s1;
  end

  // Stability counter; after reset the key must be seen released first.
  always_ff @(posedge CP) begin
    if (CLR) begin
      r_lock  <= 1'b1;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_lock) begin
      r_lock <= r_s2;
      r_cnt  <= '0;
    end else if (!w_diff) begin
      r_cnt <= '0;
    end else if (w_done) begin
      r_level <= r_s2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign Level = r_level;
  assign Press = w_done && r_s2;

endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: tick-to-enable sequencer for the sec/min/hr
// BCD chain, with a RUN / SET_HR / SET_MIN key-driven mode machine.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int REPEAT_TICKS = 2
) (
  input logic              CP,
  input logic              CLR,
  clock_time_ctrl_if.slave bus
);

  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS);

  mode_e         r_mode;
  mode_e         w_mode_nxt;
  logic          r_en_sec, w_en_sec;
  logic          r_en_min, w_en_min;
  logic          r_en_hr, w_en_hr;
  logic          r_sec_clr, w_sec_clr;
  logic          r_blink, w_blink_nxt;
  logic [RW-1:0] r_rep, w_rep_nxt;
  logic          w_inc;
  logic          w_mode_lvl, w_mode_press;
  logic          w_inc_lvl, w_inc_press;
  logic          w_sec59, w_min59;
  logic          w_hr_ok;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_mode (
    .CP(CP), .CLR(CLR), .KeyRaw(bus.KeyMode),
    .Level(w_mode_lvl), .Press(w_mode_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_inc (
    .CP(CP), .CLR(CLR), .KeyRaw(bus.KeyInc),
    .Level(w_inc_lvl), .Press(w_inc_press)
  );

  assign w_sec59 = is_59(bus.SecH, bus.SecL);
  assign w_min59 = is_59(bus.MinH, bus.MinL);
  assign w_hr_ok = (bus.HrH < 4'd2 && bus.HrL <= BCD_MAX_L)
                || (bus.HrH == 4'd2 && bus.HrL <= 4'd3);

  // Next mode and next registered outputs from tick, keys and live time.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_en_sec    = 1'b0;
    w_en_min    = 1'b0;
    w_en_hr     = 1'b0;
    w_sec_clr   = 1'b0;
    w_blink_nxt = r_blink;
    w_rep_nxt   = r_rep;
    w_inc       = 1'b0;
    unique case (r_mode)
      MODE_RUN: begin
        w_en_sec    = bus.Tick1Hz;
        w_en_min    = bus.Tick1Hz && w_sec59;
        w_en_hr     = bus.Tick1Hz && w_sec59 && w_min59;
        w_blink_nxt = 1'b0;
        w_rep_nxt   = '0;
        if (w_mode_press) w_mode_nxt = MODE_SET_HR;
      end
      MODE_SET_HR, MODE_SET_MIN: begin
        if (w_mode_press) begin
          if (r_mode == MODE_SET_HR) begin
            w_mode_nxt = MODE_SET_MIN;
          end else begin
            w_mode_nxt = MODE_RUN;
            w_sec_clr  = 1'b1;
          end
          w_blink_nxt = 1'b0;
          w_rep_nxt   = '0;
        end else begin
          w_inc = w_inc_press;
          if (bus.Tick1Hz) w_blink_nxt = ~r_blink;
          if (!w_inc_lvl) begin
            w_rep_nxt = '0;
          end else if (bus.Tick1Hz) begin
            if (r_rep == REP_LAST) w_inc = 1'b1;
            else w_rep_nxt = r_rep + 1'b1;
          end
          w_en_hr  = w_inc && (r_mode == MODE_SET_HR);
          w_en_min = w_inc && (r_mode == MODE_SET_MIN);
        end
      end
      default: begin
        w_mode_nxt  = MODE_RUN;
        w_blink_nxt = 1'b0;
        w_rep_nxt   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CP) begin
    if (CLR) begin
      r_mode    <= MODE_RUN;
      r_en_sec  <= 1'b0;
      r_en_min  <= 1'b0;
      r_en_hr   <= 1'b0;
      r_sec_clr <= 1'b0;
      r_blink   <= 1'b0;
      r_rep     <= '0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_en_sec  <= w_en_sec;
      r_en_min  <= w_en_min;
      r_en_hr   <= w_en_hr;
      r_sec_clr <= w_sec_clr;
      r_blink   <= w_blink_nxt;
      r_rep     <= w_rep_nxt;
    end
  end

  // Hours fed back must be legal BCD 00..23; a press starts from a released key.
  always_ff @(posedge CP) begin
    if (!CLR) begin
      assert (w_hr_ok);
      assert (!(w_mode_press && w_mode_lvl));
    end
  end

  assign bus.EnSec  = r_en_sec;
  assign bus.EnMin  = r_en_min;
  assign bus.EnHr   = r_en_hr;
  assign bus.SecClr = r_sec_clr;
  assign bus.Mode   = r_mode;
  assign bus.Blink  = r_blink;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed + random stimulus against a
// window-based behavioural model of keys, modes and carries.
module tb_clock_time_ctrl;
  import clock_pkg::*;

  localparam int DEB = 4;
  localparam int REP = 2;

  logic CP = 1'b0;
  logic CLR;
  int   checks = 0;
  int   errors = 0;

  clock_time_ctrl_if bus();

  clock_time_ctrl #(.DEB_CYCLES(DEB), .REPEAT_TICKS(REP)) dut (
    .CP(CP), .CLR(CLR), .bus(bus)
  );

  always #5 CP = ~CP;

  // ---------------- reference model ----------------
  int   m_mode = 0;
  bit   m_blink = 0;
  int   m_rep = 0;
  bit   m_sec = 0, m_min = 0, m_hr = 0, m_clr = 0;
  bit   mk_d1[2], mk_d2[2], mk_lvl[2], mk_arm[2], mk_press[2], mk_raw[2];
  int   mk_hist[2], mk_nval[2];
  bit   inc_lvl_before;
  bit   samp;
  bit   inc;
  int   mask;

  function automatic int bcd_val(input logic [3:0] h, input logic [3:0] l);
    if (h > 9 || l > 9) return -1;
    return int'(h) * 10 + int'(l);
  endfunction

  always @(posedge CP) begin
    mask = (1 << DEB) - 1;
    mk_raw[0] = bus.KeyMode;
    mk_raw[1] = bus.KeyInc;
    inc_lvl_before = mk_lvl[1];
    for (int k = 0; k < 2; k++) begin
      samp = mk_d2[k];
      mk_d2[k] = mk_d1[k];
      mk_d1[k] = mk_raw[k];
      mk_press[k] = 0;
      if (CLR) begin
        mk_lvl[k] = 0; mk_arm[k] = 0; mk_hist[k] = 0; mk_nval[k] = 0;
      end else begin
        if (!mk_arm[k] && samp == 0) mk_arm[k] = 1;
        if (mk_arm[k]) begin
          mk_hist[k] = ((mk_hist[k] << 1) | int'(samp)) & mask;
          if (mk_nval[k] < DEB) mk_nval[k]++;
          if (mk_nval[k] == DEB && mk_hist[k] == (mk_lvl[k] ? 0 : mask)) begin
            mk_lvl[k] = !mk_lvl[k];
            mk_press[k] = mk_lvl[k];
          end
        end
      end
    end
    m_sec = 0; m_min = 0; m_hr = 0; m_clr = 0;
    if (CLR) begin
      m_mode = 0; m_blink = 0; m_rep = 0;
    end else if (m_mode == 0) begin
      if (bus.Tick1Hz) begin
        m_sec = 1;
        m_min = (bcd_val(bus.SecH, bus.SecL) == 59);
        m_hr  = m_min && (bcd_val(bus.MinH, bus.MinL) == 59);
      end
      m_rep = 0; m_blink = 0;
      if (mk_press[0]) m_mode = 1;
    end else if (mk_press[0]) begin
      m_clr = (m_mode == 2);
      m_mode = (m_mode + 1) % 3;
      m_blink = 0; m_rep = 0;
    end else begin
      inc = mk_press[1];
      if (bus.Tick1Hz) m_blink = !m_blink;
      if (!inc_lvl_before) m_rep = 0;
      else if (bus.Tick1Hz) begin
        if (m_rep >= REP) inc = 1;
        else m_rep++;
      end
      if (inc) begin
        if (m_mode == 1) m_hr = 1;
        else m_min = 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int   n_sec, n_min, n_hr, n_clr, n_tog;
  logic prev_blink = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    n_sec = 0; n_min = 0; n_hr = 0; n_clr = 0; n_tog = 0;
  endtask

  task automatic step(input string tag);
    @(posedge CP); #1;
    chk({tag, ":EnSec"},  8'(bus.EnSec),  8'(m_sec));
    chk({tag, ":EnMin"},  8'(bus.EnMin),  8'(m_min));
    chk({tag, ":EnHr"},   8'(bus.EnHr),   8'(m_hr));
    chk({tag, ":SecClr"}, 8'(bus.SecClr), 8'(m_clr));
    chk({tag, ":Mode"},   8'(bus.Mode),   8'(m_mode));
    chk({tag, ":Blink"},  8'(bus.Blink),  8'(m_blink));
    n_sec += int'(bus.EnSec);
    n_min += int'(bus.EnMin);
    n_hr  += int'(bus.EnHr);
    n_clr += int'(bus.SecClr);
    if (bus.Blink !== prev_blink) n_tog++;
    prev_blink = bus.Blink;
  endtask

  task automatic run(input int n, input int per, input string tag);
    for (int i = 0; i < n; i++) begin
      bus.Tick1Hz = (per > 0) && (i % per == per - 1);
      step(tag);
    end
    bus.Tick1Hz = 1'b0;
  endtask

  function automatic logic [3:0] rdig(input logic [3:0] hot);
    logic [3:0] d;
    d = 4'($urandom % 16);
    return ($urandom % 3 == 0) ? hot : d;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    CLR = 1'b1;
    bus.Tick1Hz = 0; bus.KeyMode = 0; bus.KeyInc = 0;
    bus.SecH = 0; bus.SecL = 0; bus.MinH = 0; bus.MinL = 0;
    bus.HrH = 4'd1; bus.HrL = 4'd2;
    clr_cnt();
    run(3, 0, "rst");
    chk("rst_mode", 8'(bus.Mode), 8'(MODE_RUN));
    chk("rst_outs", {3'b0, bus.EnSec, bus.EnMin, bus.EnHr, bus.SecClr, bus.Blink}, 8'h00);
    CLR = 1'b0;
    run(3, 0, "idle");

    for (int s = 0; s < 59; s++) begin
      bus.SecH = 4'(s / 10); bus.SecL = 4'(s % 10);
      bus.MinH = 4'($urandom % 6); bus.MinL = 4'($urandom % 10);
      bus.Tick1Hz = 1'b1;
      step("sweep");
      bus.Tick1Hz = 1'b0;
      chk("sweep_en", {5'b0, bus.EnSec, bus.EnMin, bus.EnHr}, 8'b100);
      step("sweep_gap");
    end

    bus.SecH = 4'd5; bus.SecL = 4'd9; bus.MinH = 4'd4; bus.MinL = 4'd2;
    bus.Tick1Hz = 1'b1; step("c59"); bus.Tick1Hz = 1'b0;
    chk("c59_en", {5'b0, bus.EnSec, bus.EnMin, bus.EnHr}, 8'b110);
    step("c59_after");
    chk("c59_off", {5'b0, bus.EnSec, bus.EnMin, bus.EnHr}, 8'b000);
    bus.MinH = 4'd5; bus.MinL = 4'd9;
    bus.Tick1Hz = 1'b1; step("c5959"); bus.Tick1Hz = 1'b0;
    chk("c5959_en", {5'b0, bus.EnSec, bus.EnMin, bus.EnHr}, 8'b111);
    bus.SecH = 4'hF;
    bus.Tick1Hz = 1'b1; step("nonbcd"); bus.Tick1Hz = 1'b0;
    chk("nonbcd_en", {5'b0, bus.EnSec, bus.EnMin, bus.EnHr}, 8'b100);

    for (int i = 0; i < 40; i++) begin
      bus.SecH = rdig(4'd5); bus.SecL = rdig(4'd9);
      bus.MinH = rdig(4'd5); bus.MinL = rdig(4'd9);
      bus.Tick1Hz = ($urandom % 2 == 0);
      step("rnd_run");
    end
    bus.Tick1Hz = 1'b0;

    bus.KeyMode = 1'b1; run(3, 0, "glitch");
    bus.KeyMode = 1'b0; run(10, 0, "glitch");
    chk("glitch_mode", 8'(bus.Mode), 8'(MODE_RUN));

    bus.KeyMode = 1'b1; run(5, 0, "pm");
    chk("pm_pre", 8'(bus.Mode), 8'(MODE_RUN));
    step("pm");
    chk("pm_at6", 8'(bus.Mode), 8'(MODE_SET_HR));
    chk("pm_blink", 8'(bus.Blink), 8'd0);
    run(4, 0, "pm");
    bus.KeyMode = 1'b0; run(8, 0, "pm_rel");

    clr_cnt();
    bus.KeyInc = 1'b1; run(7, 3, "inc1");
    bus.KeyInc = 1'b0; run(12, 3, "inc1");
    chk("inc1_hr", 8'(n_hr), 8'd1);
    chk("inc1_sec", 8'(n_sec), 8'd0);
    chk("inc1_min", 8'(n_min), 8'd0);

    clr_cnt();
    bus.KeyInc = 1'b1; run(8, 0, "hold");
    run(20, 4, "hold");
    bus.KeyInc = 1'b0; run(10, 0, "hold");
    chk("hold_hr", 8'(n_hr), 8'd4);
    chk("hold_sec", 8'(n_sec), 8'd0);
    chk("hold_blink_toggles", 8'(n_tog), 8'd5);

    clr_cnt();
    bus.KeyMode = 1'b1; bus.KeyInc = 1'b1; run(6, 0, "both");
    chk("both_mode", 8'(bus.Mode), 8'(MODE_SET_MIN));
    chk("both_blink", 8'(bus.Blink), 8'd0);
    run(4, 0, "both");
    bus.KeyMode = 1'b0; bus.KeyInc = 1'b0; run(10, 0, "both");
    chk("both_inc", 8'(n_hr + n_min), 8'd0);

    clr_cnt();
    bus.KeyInc = 1'b1; run(8, 0, "incm");
    bus.KeyInc = 1'b0; run(8, 0, "incm");
    chk("incm_min", 8'(n_min), 8'd1);
    chk("incm_hr", 8'(n_hr), 8'd0);

    clr_cnt();
    bus.KeyMode = 1'b1; run(6, 0, "torun");
    chk("torun_mode", 8'(bus.Mode), 8'(MODE_RUN));
    chk("torun_secclr", 8'(bus.SecClr), 8'd1);
    run(3, 0, "torun");
    bus.KeyMode = 1'b0; run(8, 0, "torun");
    chk("torun_clr_cnt", 8'(n_clr), 8'd1);

    bus.SecH = 4'd5; bus.SecL = 4'd9; bus.MinH = 4'd1; bus.MinL = 4'd0;
    bus.KeyMode = 1'b1; run(5, 0, "tickmode");
    bus.Tick1Hz = 1'b1; step("tickmode"); bus.Tick1Hz = 1'b0;
    chk("tickmode_mode", 8'(bus.Mode), 8'(MODE_SET_HR));
    chk("tickmode_en", {5'b0, bus.EnSec, bus.EnMin, bus.EnHr}, 8'b110);
    bus.KeyMode = 1'b0; run(8, 0, "tickmode");

    bus.KeyMode = 1'b1; run(8, 0, "clrheld");
    CLR = 1'b1; step("clrheld");
    chk("clr_mode", 8'(bus.Mode), 8'(MODE_RUN));
    chk("clr_outs", {3'b0, bus.EnSec, bus.EnMin, bus.EnHr, bus.SecClr, bus.Blink}, 8'h00);
    CLR = 1'b0; run(15, 0, "clrheld");
    chk("clr_nopress", 8'(bus.Mode), 8'(MODE_RUN));
    bus.KeyMode = 1'b0; run(8, 0, "clrrel");
    bus.KeyMode = 1'b1; run(6, 0, "repress");
    chk("repress_mode", 8'(bus.Mode), 8'(MODE_SET_HR));
    bus.KeyMode = 1'b0; run(8, 0, "repress");

    for (int i = 0; i < 500; i++) begin
      bus.Tick1Hz = ($urandom % 4 == 0);
      if ($urandom % 12 == 0) bus.KeyMode = !bus.KeyMode;
      if ($urandom % 10 == 0) bus.KeyInc = !bus.KeyInc;
      CLR = ($urandom % 200 == 0);
      bus.SecH = rdig(4'd5); bus.SecL = rdig(4'd9);
      bus.MinH = rdig(4'd5); bus.MinL = rdig(4'd9);
      bus.HrH = 4'($urandom % 3);
      bus.HrL = (bus.HrH == 4'd2) ? 4'($urandom % 4) : 4'($urandom % 10);
      step("rnd");
    end
    CLR = 1'b0;
    bus.Tick1Hz = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Sequencer for the digital-clock counter chain: the seconds counter60, the minutes counter60 and the hours counter24.
- Converts a 1 Hz tick into per-counter enable pulses, with carries decoded from the live BCD values.
- Runs a mode FSM that lets two push-buttons set hours and minutes.
- Sits between the tick divider and the counter chain; also drives the display blink flag.

Parameters:
DEB_CYCLES, 4, consecutive CP samples at the same raw level needed to accept a key level change (min 2)
REPEAT_TICKS, 2, Tick1Hz pulses KeyInc must be held before auto-repeat starts (min 1)

Ports:
CP  in  1  system clock, all logic on posedge
CLR  in  1  synchronous reset, active-high
Tick1Hz  in  1  one-CP-cycle pulse, once per second
KeyMode  in  1  raw mode button, active-high, asynchronous
KeyInc  in  1  raw increment button, active-high, asynchronous
SecH, SecL  in  4 each  current seconds BCD
MinH, MinL  in  4 each  current minutes BCD
HrH, HrL  in  4 each  current hours BCD (for observation/assertions only)
EnSec  out  1  seconds counter enable, one-cycle pulse
EnMin  out  1  minutes counter enable, one-cycle pulse
EnHr  out  1  hours counter enable, one-cycle pulse
SecClr  out  1  one-cycle pulse requesting seconds clear
Mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN
Blink  out  1  display blink flag for the field being set

Behaviour:
- Reset (CLR high at posedge CP): Mode=RUN, all outputs 0, debouncers cleared (accepted level 0, count 0), repeat count 0.
  - CLR has priority over every other input.
  - CLR asserted mid-press: the press is lost; the key must be released and pressed again.
- Synchronizer/debouncer per key: 2-flop sync, then a stability counter.
  - Accepted level changes after DEB_CYCLES consecutive equal synced samples.
  - A "press" is a one-cycle pulse on an accepted 0->1 transition.
  - Latency from raw edge to press pulse: 2+DEB_CYCLES cycles.
- All enable outputs are registered.
  - Each pulse appears on the CP cycle after the triggering event and lasts exactly one cycle.
- FSM, on a KeyMode press:
  - RUN -> SET_HR
  - SET_HR -> SET_MIN
  - SET_MIN -> RUN, with SecClr pulsed in the same cycle as the transition.
  - Encoding 3 is illegal and recovers to RUN on the next cycle.
- RUN:
  - Tick gives EnSec=1.
  - EnMin=1 if Tick and {SecH,SecL}=59.
  - EnHr=1 if Tick and sec=59 and {MinH,MinL}=59.
  - Decode uses exact BCD compares; non-BCD inputs produce no carry.
  - KeyInc is ignored. Blink=0.
- SET_HR / SET_MIN:
  - EnSec=0 and no carries; the time is frozen.
  - KeyInc press gives one pulse on EnHr (SET_HR) or EnMin (SET_MIN) only.
  - Minute wrap 59->00 does not carry into hours; the counter wraps itself.
  - Blink toggles on every Tick and is forced to 0 on entry to each SET state.
- Auto-repeat:
  - While KeyInc is accepted-high in a SET state, count Ticks.
  - Once the count reaches REPEAT_TICKS, each further Tick issues one increment pulse.
  - Releasing the key or changing mode zeroes the count.
- Simultaneous events:
  - KeyMode and KeyInc press in the same cycle: mode change wins, increment discarded.
  - Tick and KeyMode press in RUN: the tick's enables are issued under RUN rules, then the mode changes.
  - Tick and a KeyInc press in a SET state: only one increment pulse is issued.

Decomposition:
- Shared package clock_pkg holds:
  - mode constants MODE_RUN/MODE_SET_HR/MODE_SET_MIN (2 bits)
  - BCD constants: BCD_MAX_L=9, SEC_MIN_MAX_H=5
- Sub-module key_debounce (param DEB_CYCLES; ports CP, CLR, KeyRaw, Level, Press), instantiated twice.

Test Plan:
- Reset, then sec=00..58 with Tick each second: EnSec pulse 1 cycle after each Tick; EnMin=EnHr=0.
- sec=59, min=42, Tick: EnSec=EnMin=1 for one cycle, EnHr=0. With sec=59, min=59: all three pulse together.
- KeyMode press with DEB_CYCLES=4: Mode=1 exactly 6 cycles after the raw rise. A 3-cycle glitch gives no change. Three presses: Mode 0->1->2->0 with SecClr pulsing once on the 2->0 step.
- Mode=1, KeyInc pressed once: exactly one EnHr pulse and no EnSec on Ticks. Holding through 5 Ticks with REPEAT_TICKS=2: 1 press pulse + 3 repeat pulses. Blink alternates 0/1 per Tick.
- Same-cycle KeyMode and KeyInc presses in Mode=1: Mode=2 and no EnHr/EnMin pulse. CLR during a held key: all outputs 0, Mode=0, and no press until the key is released and pressed again.
